sfp_sum_merge: RTL and testbench

SFP_SUM_MERGE -- requirements
Module: sfp_sum_merge

---
 rtl/sfp_pkg.sv | 25 ++
 rtl/sfp_watchdog.sv | 40 ++++
 rtl/sfp_sum_merge.sv | 164 ++++++++++++++++
 tb/tb_sfp_sum_merge.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfp_pkg.sv
// ---------------------------------------------------------------------------
// sfp_pkg
// Shared constants for the two-core row-sum merge path:
//   BW       activation width
//   BW_PSUM  partial-sum width (2*BW + 4)
//   BW_SUM   per-core row-sum width (BW_PSUM + 4)
//   WD_W     width of the merge watchdog counter
// plus the merge FSM state encoding.
// ---------------------------------------------------------------------------
package sfp_pkg;

    localparam int BW      = 8;
    localparam int BW_PSUM = 2*BW + 4;
    localparam int BW_SUM  = BW_PSUM + 4;
    localparam int WD_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_CAP  = 3'd2,
        ST_ADD  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/sfp_watchdog.sv
// ---------------------------------------------------------------------------
// sfp_watchdog
// Counts cycles in which the merge is stalled waiting for the peer core and
// flags expiry when the count reaches `limit`. The count saturates at the
// limit and is cleared whenever the merge is not waiting.
//
// Ports:
//   clk       clock, all logic on posedge
//   reset     synchronous, active-low
//   clear     drop the count to zero (merge not waiting)
//   count_en  a stalled cycle to be counted
//   expired   count has reached the limit
// ---------------------------------------------------------------------------
module sfp_watchdog
    import sfp_pkg::*;
#(
    parameter int limit = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [WD_W-1:0] LIMIT = WD_W'(limit);

    logic [WD_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            cnt <= '0;
        end else if (count_en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/sfp_sum_merge.sv
// ---------------------------------------------------------------------------
// sfp_sum_merge
// Merges this core's row sum (local internal FIFO) with the peer core's row
// sum (external FIFO) into one widened sum, then strobes the local row
// divider. Both FIFOs are popped in the same cycle; their data is valid the
// following cycle (CAP), is added in ADD and announced by div one cycle after
// DONE, i.e. 4 cycles after the pop.
//
// Optional feature (macro SFP_MERGE_TIMEOUT_EN): a watchdog that, after
// to_cycles stalled cycles with the peer FIFO empty, merges the local sum
// alone (peer taken as 0) and raises the sticky timeout flag. Without the
// macro the merge waits for the peer forever and timeout is tied low.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   start             request the next merge (ignored while busy)
//   local_empty/_sum  local FIFO status / data,   local_rd pops it
//   peer_empty/_sum   peer FIFO status / data,    fifo_ext_rd pops it
//   sum_2core         merged sum, held until the next merge
//   div               one-cycle strobe to the row divider
//   busy              FSM not idle
//   zero              merged sum was zero and has been forced to 1
//   timeout           last merge used the local sum only
//   row_cnt           completed merges, modulo 16
// ---------------------------------------------------------------------------
module sfp_sum_merge
    import sfp_pkg::*;
#(
    parameter int bw        = BW,
    parameter int bw_psum   = 2*bw + 4,
    parameter int to_cycles = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               local_empty,
    input  logic [bw_psum+3:0] local_sum,
    output logic               local_rd,
    input  logic               peer_empty,
    input  logic [bw_psum+3:0] peer_sum,
    output logic               fifo_ext_rd,
    output logic [bw_psum+4:0] sum_2core,
    output logic               div,
    output logic               busy,
    output logic               zero,
    output logic               timeout,
    output logic [3:0]         row_cnt
);

    // Row sums carry the same guard bits over the psum width as the package.
    localparam int SUM_W = bw_psum + (BW_SUM - BW_PSUM);

    // One extra bit so local+peer can never wrap.
    function automatic logic [SUM_W:0] add_ext(input logic [SUM_W-1:0] a,
                                               input logic [SUM_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // The divider cannot take a zero denominator; substitute 1.
    function automatic logic [SUM_W:0] force_nonzero(input logic [SUM_W:0] s);
        return (s == '0) ? {{SUM_W{1'b0}}, 1'b1} : s;
    endfunction

    state_t           state;
    state_t           state_nxt;
    logic             pop_both;
    logic             pop_local;
    logic             wd_fire;
    logic             local_only;
    logic [SUM_W-1:0] local_p1;
    logic [SUM_W-1:0] peer_p1;
    logic [SUM_W:0]   sum_p2;

    always_comb begin
        state_nxt = state;
        pop_both  = 1'b0;
        pop_local = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (!local_empty && !peer_empty) begin
                    pop_both  = 1'b1;
                    state_nxt = ST_CAP;
                end else if (wd_fire && !local_empty) begin
                    pop_local = 1'b1;
                    state_nxt = ST_CAP;
                end
            end
            ST_CAP:  state_nxt = ST_ADD;
            ST_ADD:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Pops are qualified by reset so a reset cycle can never consume an entry
    // that the aborted merge would then lose.
    assign local_rd    = reset & (pop_both | pop_local);
    assign fifo_ext_rd = reset & pop_both;
    assign busy        = (state != ST_IDLE);

`ifdef SFP_MERGE_TIMEOUT_EN
    sfp_watchdog #(
        .limit    (to_cycles)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (state != ST_WAIT),
        .count_en ((state == ST_WAIT) && peer_empty),
        .expired  (wd_fire)
    );
`else
    logic unused_cfg;

    assign wd_fire    = 1'b0;
    assign timeout    = 1'b0;
    assign unused_cfg = ^to_cycles;
`endif

    // Control state and held outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            div        <= 1'b0;
            zero       <= 1'b0;
            row_cnt    <= '0;
            sum_2core  <= '0;
            local_only <= 1'b0;
`ifdef SFP_MERGE_TIMEOUT_EN
            timeout    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            div   <= (state == ST_DONE);
            if (state == ST_WAIT) begin
                local_only <= pop_local;
            end
            if (state == ST_ADD) begin
                sum_2core <= force_nonzero(sum_p2);
                zero      <= (sum_p2 == '0);
`ifdef SFP_MERGE_TIMEOUT_EN
                timeout   <= local_only;
`endif
            end
            if (state == ST_DONE) begin
                row_cnt <= row_cnt + 4'd1;
            end
        end
    end

    // ---- stage p1: capture FIFO data, valid the cycle after the pop ----
    always_ff @(posedge clk) begin
        if (state == ST_CAP) begin
            local_p1 <= local_sum;
            peer_p1  <= local_only ? '0 : peer_sum;
        end
    end

    // ---- stage p2: widened add, registered into sum_2core in ADD ----
    assign sum_p2 = add_ext(local_p1, peer_p1);

endmodule

// File: tb/tb_sfp_sum_merge.sv
module tb_sfp_sum_merge;

    localparam int BWL = 8;
    localparam int PS  = 2*BWL + 4;
    localparam int SW  = PS + 4;
    localparam int TO  = 255;
    localparam logic [SW-1:0] MAXV = {SW{1'b1}};

    logic          clk = 1'b0;
    logic          reset, start, local_empty, peer_empty;
    logic [SW-1:0] local_sum, peer_sum;
    logic          local_rd, fifo_ext_rd, div, busy, zero, timeout;
    logic [SW:0]   sum_2core;
    logic [3:0]    row_cnt;

    always #5 clk = ~clk;

    sfp_sum_merge #(
        .bw          (BWL),
        .bw_psum     (PS),
        .to_cycles   (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .local_empty (local_empty),
        .local_sum   (local_sum),
        .local_rd    (local_rd),
        .peer_empty  (peer_empty),
        .peer_sum    (peer_sum),
        .fifo_ext_rd (fifo_ext_rd),
        .sum_2core   (sum_2core),
        .div         (div),
        .busy        (busy),
        .zero        (zero),
        .timeout     (timeout),
        .row_cnt     (row_cnt)
    );

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, n_pops = 0, n_div = 0, last_pop_cyc = 0;

    // FIFO contents as seen by the bench
    logic [SW-1:0] local_q[$];
    logic [SW-1:0] peer_q[$];
    logic [SW-1:0] pend_l, pend_p;
    bit            pend_ok = 0, pend_peer = 0;

    // reference model: one expected result per popped pair
    longint exp_sum_q[$];
    bit     exp_zero_q[$];
    bit     exp_to_q[$];
    int     exp_due_q[$];
    int     model_rows = 0;

    // values seen at the most recent div
    longint act_sum;
    bit     act_zero, act_to;
    int     act_row;

    typedef struct {
        logic [SW-1:0] l;
        logic [SW-1:0] p;
        longint        s;
        bit            z;
    } vec_t;
    vec_t tv[8];

    task automatic chk(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic observe();
        logic [SW-1:0] l, p;
        longint e;
        bit z;
        if (local_rd || fifo_ext_rd) begin
            n_pops++;
            last_pop_cyc = cyc;
            chk("pop_has_local", local_rd, 1);
            if (local_rd) chk("pop_local_nonempty", local_empty, 0);
            if (fifo_ext_rd) chk("pop_peer_nonempty", peer_empty, 0);
            else begin
`ifdef SFP_MERGE_TIMEOUT_EN
                chk("solo_pop_peer_empty", peer_empty, 1);
`else
                chk("pop_pair", fifo_ext_rd, 1);
`endif
            end
            l = (local_rd && local_q.size() > 0) ? local_q.pop_front() : '0;
            p = (fifo_ext_rd && peer_q.size() > 0) ? peer_q.pop_front() : '0;
            pend_l = l; pend_p = p; pend_ok = 1; pend_peer = fifo_ext_rd;
            e = longint'(l) + longint'(p);
            z = (e == 0);
            if (z) e = 1;
            exp_sum_q.push_back(e);
            exp_zero_q.push_back(z);
            exp_to_q.push_back(!fifo_ext_rd);
            exp_due_q.push_back(cyc + 4);
        end
        if (div) begin
            n_div++;
            act_sum = longint'(sum_2core); act_zero = zero; act_to = timeout; act_row = row_cnt;
            if (exp_sum_q.size() == 0) chk("div_unexpected", 1, 0);
            else begin
                model_rows = (model_rows + 1) % 16;
                chk("merge_sum", longint'(sum_2core), exp_sum_q.pop_front());
                chk("merge_zero", zero, exp_zero_q.pop_front());
                chk("merge_timeout", timeout, exp_to_q.pop_front());
                chk("merge_latency", cyc, exp_due_q.pop_front());
                chk("merge_row_cnt", row_cnt, model_rows);
            end
        end
    endtask

    // FIFO data is only meaningful the cycle after a pop; garbage otherwise.
    task automatic present();
        local_sum = pend_ok ? pend_l : SW'($urandom);
        peer_sum  = (pend_ok && pend_peer) ? pend_p : SW'($urandom);
        pend_ok = 0;
        local_empty = (local_q.size() == 0);
        peer_empty  = (peer_q.size() == 0);
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        cyc++;
        present();
    endtask

    task automatic push_l(input logic [SW-1:0] v);
        local_q.push_back(v);
        local_empty = 0;
    endtask

    task automatic push_p(input logic [SW-1:0] v);
        peer_q.push_back(v);
        peer_empty = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_div(input string nm, input int budget);
        int d0 = n_div;
        int k = 0;
        while (n_div == d0 && k < budget) begin tick(); k++; end
        chk(nm, n_div - d0, 1);
    endtask

    task automatic wait_pop(input string nm, input int budget);
        int p0 = n_pops;
        int k = 0;
        while (n_pops == p0 && k < budget) begin tick(); k++; end
        chk(nm, n_pops - p0, 1);
    endtask

    task automatic merge(input logic [SW-1:0] l, input logic [SW-1:0] p);
        push_l(l);
        push_p(p);
        pulse_start();
        wait_div("merge_div", 20);
    endtask

    function automatic logic [SW-1:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return MAXV;
            default: return SW'($urandom);
        endcase
    endfunction

    task automatic rand_merge();
        int dl = $urandom_range(0, 3);
        int dp = $urandom_range(0, 3);
        logic [SW-1:0] l = rnd_val();
        logic [SW-1:0] p = rnd_val();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            if (i == dl) push_l(l);
            if (i == dp) push_p(p);
            tick();
        end
        wait_div("rand_div", 20);
    endtask

    initial begin
        int p0, d0, w0;
        tv[0] = '{l: 24'd1000,     p: 24'd2500,    s: 3500,     z: 0};
        tv[1] = '{l: 24'd7,        p: 24'd9,       s: 16,       z: 0};
        tv[2] = '{l: 24'd0,        p: 24'd0,       s: 1,        z: 1};
        tv[3] = '{l: 24'd5,        p: 24'd5,       s: 10,       z: 0};
        tv[4] = '{l: MAXV,         p: MAXV,        s: 33554430, z: 0};
        tv[5] = '{l: MAXV,         p: 24'd0,       s: 16777215, z: 0};
        tv[6] = '{l: 24'd0,        p: 24'd1,       s: 1,        z: 0};
        tv[7] = '{l: 24'd12345678, p: 24'd4000000, s: 16345678, z: 0};

        reset = 0; start = 0; local_empty = 1; peer_empty = 1;
        local_sum = '0; peer_sum = '0;
        repeat (3) tick();
        chk("rst_local_rd", local_rd, 0);
        chk("rst_fifo_ext_rd", fifo_ext_rd, 0);
        chk("rst_div", div, 0);
        chk("rst_busy", busy, 0);
        chk("rst_zero", zero, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_sum_2core", longint'(sum_2core), 0);
        chk("rst_row_cnt", row_cnt, 0);
        reset = 1;
        tick();

        // table of directed merges
        for (int i = 0; i < 8; i++) begin
            merge(tv[i].l, tv[i].p);
            chk("tbl_sum", act_sum, tv[i].s);
            chk("tbl_zero", act_zero, tv[i].z);
            chk("tbl_busy_after", busy, 0);
            if (i == 0) chk("tbl_first_row_cnt", act_row, 1);
        end

        // a second start while busy is ignored
        push_l(24'd11); push_p(24'd22); push_l(24'd33); push_p(24'd44);
        p0 = n_pops;
        pulse_start();
        tick();
        pulse_start();
        wait_div("busy_div", 20);
        repeat (8) tick();
        chk("busy_start_ignored", n_pops - p0, 1);
        chk("busy_queue_left", local_q.size(), 1);
        pulse_start();
        wait_div("busy_second_div", 20);
        chk("busy_second_sum", act_sum, 77);

        // reset in CAP aborts the merge
        push_l(24'd500); push_p(24'd600);
        pulse_start();
        wait_pop("rstcap_pop", 10);
        reset = 0;
        exp_sum_q.delete(); exp_zero_q.delete(); exp_to_q.delete(); exp_due_q.delete();
        model_rows = 0;
        tick();
        chk("rstcap_busy", busy, 0);
        chk("rstcap_div", div, 0);
        chk("rstcap_sum", longint'(sum_2core), 0);
        chk("rstcap_row_cnt", row_cnt, 0);
        chk("rstcap_local_rd", local_rd, 0);
        reset = 1;
        d0 = n_div;
        repeat (8) tick();
        chk("rstcap_no_div", n_div - d0, 0);
        merge(24'd100, 24'd200);
        chk("rstcap_after_sum", act_sum, 300);
        chk("rstcap_after_row", act_row, 1);

        // row counter wrap: 16 more merges brings 1 back to 1
        merge(MAXV, MAXV);
        chk("wrap_max_sum", act_sum, 33554430);
        for (int i = 0; i < 15; i++) rand_merge();
        chk("wrap_row_cnt", row_cnt, 1);

        // peer empty for 20 cycles
        push_l(24'd7);
        p0 = n_pops;
        pulse_start();
        repeat (20) tick();
        chk("hold_no_pop", n_pops - p0, 0);
        chk("hold_busy", busy, 1);
        push_p(24'd9);
        wait_div("hold_div", 20);
        chk("hold_sum", act_sum, 16);
        chk("hold_timeout", act_to, 0);

        for (int i = 0; i < 25; i++) rand_merge();

`ifdef SFP_MERGE_TIMEOUT_EN
        push_l(24'd42);
        pulse_start();
        w0 = cyc;
        wait_pop("to_pop", TO + 20);
        chk("to_wait_cycles", last_pop_cyc - w0, TO);
        wait_div("to_div", 20);
        chk("to_sum", act_sum, 42);
        chk("to_flag", act_to, 1);
        merge(24'd3, 24'd4);
        chk("to_clear_sum", act_sum, 7);
        chk("to_clear_flag", act_to, 0);
`else
        push_l(24'd42);
        pulse_start();
        w0 = cyc;
        p0 = n_pops;
        repeat (TO + 20) tick();
        chk("nowd_no_pop", n_pops - p0, 0);
        chk("nowd_timeout", timeout, 0);
        chk("nowd_wait_len", cyc - w0, TO + 20);
        push_p(24'd1);
        wait_div("nowd_div", 20);
        chk("nowd_sum", act_sum, 43);
        chk("nowd_flag", act_to, 0);
`endif

        repeat (4) tick();
        chk("end_no_pending", exp_sum_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
